// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and helpers for the UART frame feeder.
//   frame_state_t : frame sequencer states (IDLE, SYNC, LEN, HI, LO, CSUM)
//   byte_state_t  : per-byte handshake states (ISSUE, WAIT)
//   SYNC_DEFAULT  : default first byte of every frame
//   hi_byte()     : upper sample bits, zero-extended to one byte
package uart_frame_pkg;

   typedef enum logic [2:0] {IDLE, SYNC, LEN, HI, LO, CSUM} frame_state_t;
   typedef enum logic       {ISSUE, WAIT} byte_state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // smp is the sample zero-padded to 16 bits; w is the real sample width (9..16).
   // The mask keeps the result clean even if the caller pads with non-zero bits.
   function automatic logic [7:0] hi_byte(input logic [15:0] smp, input int unsigned w);
      logic [7:0] mask;
      mask = 8'((16'd1 << (w - 8)) - 16'd1);
      return smp[15:8] & mask;
   endfunction

endpackage

// File: rtl/uart_frame_if.sv
// uart_frame_if: sample input stream plus UART byte handshake.
//   s_data/s_valid/s_ready : ADC sample stream into the feeder
//   tx_data/start_tx       : byte request towards the UART
//   tx_ready               : UART idle indication
//   busy/overflow          : feeder status
// master = sample producer / UART side, slave = the frame feeder.
interface uart_frame_if #(
   parameter int SAMPLE_W = 12
);
   logic [SAMPLE_W-1:0] s_data;
   logic                s_valid;
   logic                s_ready;
   logic [7:0]          tx_data;
   logic                start_tx;
   logic                tx_ready;
   logic                busy;
   logic                overflow;

   modport master (
      output s_data, s_valid, tx_ready,
      input  s_ready, tx_data, start_tx, busy, overflow
   );

   modport slave (
      input  s_data, s_valid, tx_ready,
      output s_ready, tx_data, start_tx, busy, overflow
   );
endinterface

// File: rtl/uart_frame_tx_sample_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request / data (ignored when full)
//   pop, dout  : read request (ignored when empty) / head of queue
//   full, empty, count : occupancy, count is log2(DEPTH)+1 bits
// DEPTH must be a power of 2 so the pointers wrap by natural overflow.
module sample_fifo #(
   parameter int W     = 12,
   parameter int DEPTH = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: buffers ADC samples and feeds them to a UART as byte frames
// SYNC, LEN, {HI,LO} x FRAME_LEN, optional CSUM.
//   clk, rst : system clock (shared with the UART), synchronous active-high reset
//   bus      : uart_frame_if.slave (sample stream in, UART byte handshake out,
//              busy / sticky overflow status)
// Build option: define UART_FRAME_CSUM_EN to append the XOR checksum byte
// (LEN and all HI/LO bytes). Without it the frame is 2+2*FRAME_LEN bytes.
// The interface SAMPLE_W must equal this module's SAMPLE_W.
//
// frame state | meaning
// IDLE        | waiting for FRAME_LEN samples in the FIFO
// SYNC        | sending the sync byte, clears sample counter/checksum
// LEN         | sending FRAME_LEN-1
// HI          | sending upper bits of the FIFO head
// LO          | sending lower 8 bits, pops the FIFO when done
// CSUM        | sending the checksum (checksum builds only)
//
// byte state  | meaning
// ISSUE       | start_tx high until the UART drops tx_ready
// WAIT        | start_tx low until tx_ready returns high
module uart_frame_tx
   import uart_frame_pkg::*;
#(
   parameter int         SAMPLE_W   = 12,
   parameter int         FRAME_LEN  = 64,
   parameter int         FIFO_DEPTH = 128,
   parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT
) (
   input logic        clk,
   input logic        rst,
   uart_frame_if.slave bus
);
   localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [7:0] LEN_BYTE = 8'(FRAME_LEN - 1);

   frame_state_t        frame_q, frame_d;
   byte_state_t         byte_q, byte_d;
   logic [8:0]          sent_q, sent_d;
   logic                overflow_q, overflow_d;
   logic [SAMPLE_W-1:0] head;
   logic [CW-1:0]       fifo_count;
   logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [7:0]          cur_byte;
`ifdef UART_FRAME_CSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   assign fifo_push  = bus.s_valid && !fifo_full;
   assign overflow_d = overflow_q || (bus.s_valid && fifo_full);

   sample_fifo #(
      .W     (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (bus.s_data),
      .pop   (fifo_pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      frame_d  = frame_q;
      byte_d   = byte_q;
      sent_d   = sent_q;
      fifo_pop = 1'b0;
      cur_byte = 8'h00;
`ifdef UART_FRAME_CSUM_EN
      csum_d   = csum_q;
`endif

      // The FIFO head and checksum only change at byte completion, so the
      // selected byte is stable from ISSUE entry until WAIT exit.
      case (frame_q)
         SYNC:    cur_byte = SYNC_BYTE;
         LEN:     cur_byte = LEN_BYTE;
         HI:      cur_byte = hi_byte(16'(head), SAMPLE_W);
         LO:      cur_byte = head[7:0];
`ifdef UART_FRAME_CSUM_EN
         CSUM:    cur_byte = csum_q;
`endif
         default: cur_byte = 8'h00;
      endcase

      if (frame_q == IDLE) begin
         byte_d = ISSUE;
         if (fifo_count >= CW'(FRAME_LEN)) frame_d = SYNC;
      end else if (byte_q == ISSUE) begin
         if (!bus.tx_ready) byte_d = WAIT;
      end else if (bus.tx_ready) begin
         byte_d = ISSUE;
         case (frame_q)
            SYNC: frame_d = LEN;
            LEN: begin
               frame_d = HI;
`ifdef UART_FRAME_CSUM_EN
               csum_d  = csum_q ^ cur_byte;
`endif
            end
            HI: begin
               frame_d = LO;
`ifdef UART_FRAME_CSUM_EN
               csum_d  = csum_q ^ cur_byte;
`endif
            end
            LO: begin
               fifo_pop = !fifo_empty;
               sent_d   = sent_q + 9'd1;
`ifdef UART_FRAME_CSUM_EN
               csum_d   = csum_q ^ cur_byte;
               frame_d  = (sent_d < 9'(FRAME_LEN)) ? HI : CSUM;
`else
               frame_d  = (sent_d < 9'(FRAME_LEN)) ? HI : IDLE;
`endif
            end
            default: frame_d = IDLE;
         endcase
      end

      if (frame_q == SYNC) begin
         sent_d = '0;
`ifdef UART_FRAME_CSUM_EN
         csum_d = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q    <= IDLE;
         byte_q     <= ISSUE;
         sent_q     <= '0;
         overflow_q <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         frame_q    <= frame_d;
         byte_q     <= byte_d;
         sent_q     <= sent_d;
         overflow_q <= overflow_d;
`ifdef UART_FRAME_CSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign bus.s_ready  = !fifo_full;
   assign bus.tx_data  = cur_byte;
   assign bus.start_tx = (frame_q != IDLE) && (byte_q == ISSUE);
   assign bus.busy     = (frame_q != IDLE);
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: self-checking bench for uart_frame_tx (FRAME_LEN=4,
// FIFO_DEPTH=128, SAMPLE_W=12). A UART model accepts bytes and checks them
// against a queue of expected bytes; works with or without UART_FRAME_CSUM_EN.
module tb_uart_frame_tx;
   localparam int FL = 4;
`ifdef UART_FRAME_CSUM_EN
   localparam int FB = 3 + 2*FL;
`else
   localparam int FB = 2 + 2*FL;
`endif

   typedef struct {
      logic [11:0] smp;
      logic [7:0]  hi;
      logic [7:0]  lo;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_frame_if #(.SAMPLE_W(12)) bus_if ();

   uart_frame_tx #(
      .SAMPLE_W   (12),
      .FRAME_LEN  (FL),
      .FIFO_DEPTH (128),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q [$];
   int         n_bytes = 0;
   bit         hold_low = 1'b0;
   int         accept_dly = 3;
   vec_t       vecs [12];
   vec_t       big [128];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // UART model: samples start_tx when idle, drops tx_ready accept_dly cycles
   // later, raises it again 20 cycles after that.
   int         u_state = 0;
   int         u_cnt = 0;
   logic [7:0] u_byte = 8'h00;
   bit         u_stable = 1'b1;

   initial begin
      bus_if.tx_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         if (hold_low) begin
            bus_if.tx_ready = 1'b0;
            u_state = 0;
         end else if (rst) begin
            bus_if.tx_ready = 1'b1;
            u_state = 0;
         end else begin
            case (u_state)
               0: begin
                  bus_if.tx_ready = 1'b1;
                  if (bus_if.start_tx) begin
                     n_bytes++;
                     if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", bus_if.tx_data);
                     end else begin
                        check("byte", 32'(bus_if.tx_data), 32'(exp_q.pop_front()));
                     end
                     u_byte   = bus_if.tx_data;
                     u_stable = 1'b1;
                     u_cnt    = 1;
                     u_state  = 1;
                  end
               end
               1: begin
                  if (!bus_if.start_tx || bus_if.tx_data !== u_byte) u_stable = 1'b0;
                  if (u_cnt >= accept_dly) begin
                     bus_if.tx_ready = 1'b0;
                     u_cnt   = 0;
                     u_state = 2;
                  end else begin
                     u_cnt++;
                  end
               end
               default: begin
                  if (bus_if.start_tx || bus_if.tx_data !== u_byte) u_stable = 1'b0;
                  u_cnt++;
                  if (u_cnt == 20) begin
                     bus_if.tx_ready = 1'b1;
                     u_state = 0;
                     check("byte_hold", 32'(u_stable), 32'd1);
                  end
               end
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic queue_frame(input vec_t f [4], input bit skip_sync);
`ifdef UART_FRAME_CSUM_EN
      logic [7:0] c;
      c = 8'h03;
`endif
      if (!skip_sync) exp_q.push_back(8'hA5);
      exp_q.push_back(8'h03);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(f[i].hi);
         exp_q.push_back(f[i].lo);
`ifdef UART_FRAME_CSUM_EN
         c = c ^ f[i].hi ^ f[i].lo;
`endif
      end
`ifdef UART_FRAME_CSUM_EN
      exp_q.push_back(c);
`endif
   endtask

   task automatic queue_from_table(input int base);
      vec_t fr [4];
      for (int i = 0; i < 4; i++) fr[i] = vecs[base + i];
      queue_frame(fr, 1'b0);
   endtask

   task automatic push_seq(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         bus_if.s_data  = vecs[base + i].smp;
         bus_if.s_valid = 1'b1;
         tick();
      end
      bus_if.s_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus_if.busy || u_state != 0) && n < budget) begin
         tick();
         n++;
      end
      check({name, "_timeout"}, 32'(n < budget), 32'd1);
      check({name, "_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int nb0;
      int n;
      int gap;
      vec_t fr [4];

      vecs[0]  = '{12'h123, 8'h01, 8'h23};
      vecs[1]  = '{12'hABC, 8'h0A, 8'hBC};
      vecs[2]  = '{12'h000, 8'h00, 8'h00};
      vecs[3]  = '{12'hFFF, 8'h0F, 8'hFF};
      vecs[4]  = '{12'h5A5, 8'h05, 8'hA5};
      vecs[5]  = '{12'h0FF, 8'h00, 8'hFF};
      vecs[6]  = '{12'h100, 8'h01, 8'h00};
      vecs[7]  = '{12'h876, 8'h08, 8'h76};
      vecs[8]  = '{12'h321, 8'h03, 8'h21};
      vecs[9]  = '{12'hA0F, 8'h0A, 8'h0F};
      vecs[10] = '{12'h7E1, 8'h07, 8'hE1};
      vecs[11] = '{12'hC3C, 8'h0C, 8'h3C};

      rst = 1'b1;
      bus_if.s_valid = 1'b0;
      bus_if.s_data  = '0;
      repeat (3) tick();
      check("rst_s_ready",  32'(bus_if.s_ready),  32'd1);
      check("rst_start_tx", 32'(bus_if.start_tx), 32'd0);
      check("rst_tx_data",  32'(bus_if.tx_data),  32'h00);
      check("rst_busy",     32'(bus_if.busy),     32'd0);
      check("rst_overflow", 32'(bus_if.overflow), 32'd0);
      rst = 1'b0;
      tick();

      // T1: one frame from the table
      nb0 = n_bytes;
      queue_from_table(0);
      push_seq(0, 4);
      wait_drain(2000, "t1");
      check("t1_bytes", 32'(n_bytes - nb0), 32'(FB));
      check("t1_busy", 32'(bus_if.busy), 32'd0);

      // T4: UART slow to accept, start_tx/tx_data must hold with no re-issue
      accept_dly = 12;
      nb0 = n_bytes;
      queue_from_table(4);
      push_seq(4, 4);
      wait_drain(3000, "t4");
      check("t4_bytes", 32'(n_bytes - nb0), 32'(FB));
      accept_dly = 3;

      // T6: two back-to-back frames separated by one IDLE cycle
      nb0 = n_bytes;
      queue_from_table(4);
      queue_from_table(8);
      push_seq(4, 8);
      n = 0;
      while (!bus_if.busy && n < 10) begin tick(); n++; end
      while (bus_if.busy && n < 2000) begin tick(); n++; end
      gap = 0;
      while (!bus_if.busy && gap < 50) begin tick(); gap++; end
      check("t6_gap", 32'(gap), 32'd1);
      wait_drain(3000, "t6");
      check("t6_bytes", 32'(n_bytes - nb0), 32'(2*FB));

      // T3: fill the FIFO with the UART stalled, then overflow
      hold_low = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 128; i++) begin
         big[i].smp = 12'(i*29 + 7);
         big[i].hi  = {4'h0, big[i].smp[11:8]};
         big[i].lo  = big[i].smp[7:0];
         bus_if.s_data  = big[i].smp;
         bus_if.s_valid = 1'b1;
         tick();
      end
      bus_if.s_valid = 1'b0;
      check("t3_full_s_ready", 32'(bus_if.s_ready), 32'd0);
      check("t3_no_ovf_yet",   32'(bus_if.overflow), 32'd0);
      check("t3_stalled",      32'(bus_if.start_tx), 32'd0);
      bus_if.s_data  = 12'h555;
      bus_if.s_valid = 1'b1;
      tick();
      bus_if.s_valid = 1'b0;
      check("t3_overflow", 32'(bus_if.overflow), 32'd1);
      check("t3_still_full", 32'(bus_if.s_ready), 32'd0);
      // The SYNC byte of the first frame was taken while tx_ready was low.
      for (int f = 0; f < 32; f++) begin
         for (int j = 0; j < 4; j++) fr[j] = big[f*4 + j];
         queue_frame(fr, f == 0);
      end
      hold_low = 1'b0;
      wait_drain(20000, "t3");
      check("t3_sticky", 32'(bus_if.overflow), 32'd1);

      // T5: reset during the LO byte of the second sample
      nb0 = n_bytes;
      queue_from_table(4);
      push_seq(4, 8);
      n = 0;
      while ((n_bytes - nb0) < 6 && n < 2000) begin tick(); n++; end
      check("t5_reach_lo", 32'(n < 2000), 32'd1);
      rst = 1'b1;
      exp_q.delete();
      tick();
      rst = 1'b0;
      check("t5_start_tx", 32'(bus_if.start_tx), 32'd0);
      check("t5_busy",     32'(bus_if.busy),     32'd0);
      check("t5_overflow", 32'(bus_if.overflow), 32'd0);
      check("t5_s_ready",  32'(bus_if.s_ready),  32'd1);

      // T2: three samples never start a frame (also proves the FIFO was emptied)
      push_seq(0, 3);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus_if.start_tx || bus_if.busy) n++;
         tick();
      end
      check("t2_no_start", 32'(n), 32'd0);
      queue_from_table(0);
      bus_if.s_data  = vecs[3].smp;
      bus_if.s_valid = 1'b1;
      tick();
      bus_if.s_valid = 1'b0;
      n = 0;
      while (!bus_if.start_tx && n < 2) begin tick(); n++; end
      check("t2_start", 32'(bus_if.start_tx), 32'd1);
      check("t2_sync",  32'(bus_if.tx_data),  32'hA5);
      wait_drain(2000, "t2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
